// File: rtl/spi_master_multi.sv
// Parametrised SPI master: TX/RX FIFOs, multiple chip selects, internal SCK
// divider, CPOL/CPHA, LSB-first option and sticky RX overflow flag.

module spi_master_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOG2_DEPTH = 4
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             present,
    output logic             half_full,
    output logic             full
);
    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
    localparam int unsigned CNT_W = LOG2_DEPTH + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && present;
    assign present   = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign half_full = (count >= CNT_W'(DEPTH / 2));
    assign dout      = present ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
            if (do_pop)  rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module spi_master_multi #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LOG2_DEPTH = 4,
    parameter int unsigned NUM_CS     = 4,
    parameter int unsigned DIV_WIDTH  = 8,
    localparam int unsigned CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic [DIV_WIDTH-1:0]  clkDiv,
    input  logic [CS_W-1:0]       csSel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsbFirst,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  write,
    input  logic                  read,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  sck,
    output logic [NUM_CS-1:0]     nCs,
    output logic                  busy,
    output logic                  txDataPresent,
    output logic                  txHalfFull,
    output logic                  txFull,
    output logic                  rxDataPresent,
    output logic                  rxHalfFull,
    output logic                  rxFull,
    output logic                  rxOverflow,
    output logic [DATA_WIDTH-1:0] dataOut
);
    localparam int unsigned HC_W = $clog2(2 * DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t                state, state_n;
    logic [DIV_WIDTH-1:0]  div_lat, div_cnt;
    logic [CS_W-1:0]       cs_lat, cs_use;
    logic                  cpol_lat, cpha_lat, lsb_lat;
    logic                  lsb_use, cpol_use, from_idle;
    logic [HC_W-1:0]       hcnt;
    logic [DATA_WIDTH-1:0] tx_sh, rx_sh, tx_word, tx_next, tx_head;
    logic [NUM_CS-1:0]     cs_dec;
    logic                  sck_q, tick, last_half;
    logic                  enter_load, bypass, lead, trail, word_end, sample, update;

    // A write landing on the final half-period goes straight to the shifter.
    spi_master_fifo #(.WIDTH(DATA_WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) u_tx (
        .clk(clk), .nRst(nRst), .push(write && !bypass), .pop(enter_load && !bypass),
        .din(dataIn), .dout(tx_head), .present(txDataPresent),
        .half_full(txHalfFull), .full(txFull)
    );

    spi_master_fifo #(.WIDTH(DATA_WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) u_rx (
        .clk(clk), .nRst(nRst), .push(word_end), .pop(read),
        .din(rx_sh), .dout(dataOut), .present(rxDataPresent),
        .half_full(rxHalfFull), .full(rxFull)
    );

    assign tick      = (state != IDLE) && (div_cnt == div_lat);
    assign last_half = (hcnt == HC_W'(2 * DATA_WIDTH - 1));
    assign from_idle = (state == IDLE);
    assign cs_use    = from_idle ? csSel : cs_lat;
    assign lsb_use   = from_idle ? lsbFirst : lsb_lat;
    assign cpol_use  = from_idle ? cpol : cpol_lat;
    assign tx_word   = bypass ? dataIn : tx_head;
    assign tx_next   = lsb_lat ? (tx_sh >> 1) : (tx_sh << 1);
    assign sample    = cpha_lat ? trail : lead;
    assign update    = cpha_lat ? (lead && (state == SHIFT))
                                : (trail && (hcnt != HC_W'(2 * DATA_WIDTH - 2)));
    assign sck       = from_idle ? cpol : sck_q;

    always_comb begin
        cs_dec = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (cs_use == CS_W'(i)) cs_dec[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        enter_load = 1'b0;
        bypass     = 1'b0;
        lead       = 1'b0;
        trail      = 1'b0;
        word_end   = 1'b0;
        case (state)
            IDLE: begin
                if (txDataPresent) begin
                    state_n    = LOAD;
                    enter_load = 1'b1;
                end
            end
            LOAD: begin
                if (tick) begin
                    state_n = SHIFT;
                    lead    = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (last_half) begin
                        word_end = 1'b1;
                        if ((txDataPresent || write) && (csSel == cs_lat)) begin
                            state_n    = LOAD;
                            enter_load = 1'b1;
                            bypass     = !txDataPresent;
                        end else begin
                            state_n = GAP;
                        end
                    end else if (hcnt[0]) begin
                        lead = 1'b1;
                    end else begin
                        trail = 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Divider, shifters and pin drivers, all stepped by the FSM strobes.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            div_cnt    <= '0;
            div_lat    <= '0;
            cs_lat     <= '0;
            cpol_lat   <= 1'b0;
            cpha_lat   <= 1'b0;
            lsb_lat    <= 1'b0;
            hcnt       <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            nCs        <= '1;
            mosi       <= 1'b0;
            sck_q      <= 1'b0;
            busy       <= 1'b0;
            rxOverflow <= 1'b0;
        end else begin
            if (from_idle || tick) div_cnt <= '0;
            else                   div_cnt <= div_cnt + DIV_WIDTH'(1);

            if (from_idle && enter_load) begin
                div_lat  <= clkDiv;
                cs_lat   <= csSel;
                cpol_lat <= cpol;
                cpha_lat <= cpha;
                lsb_lat  <= lsbFirst;
            end

            if (enter_load) begin
                tx_sh <= tx_word;
                mosi  <= lsb_use ? tx_word[0] : tx_word[DATA_WIDTH-1];
                nCs   <= cs_dec;
                sck_q <= cpol_use;
                busy  <= 1'b1;
                hcnt  <= '0;
            end else if (word_end) begin
                nCs <= '1;
            end

            if (state == SHIFT && tick && !last_half) hcnt <= hcnt + HC_W'(1);
            if (lead)  sck_q <= ~cpol_lat;
            if (trail) sck_q <= cpol_lat;

            if (sample) begin
                rx_sh <= lsb_lat ? {miso, rx_sh[DATA_WIDTH-1:1]}
                                 : {rx_sh[DATA_WIDTH-2:0], miso};
            end
            if (update) begin
                tx_sh <= tx_next;
                mosi  <= lsb_lat ? tx_next[0] : tx_next[DATA_WIDTH-1];
            end

            if (state == GAP && tick) busy <= 1'b0;

            if (word_end && rxFull) rxOverflow <= 1'b1;
            else if (read)          rxOverflow <= 1'b0;
        end
    end
endmodule
